// File: rtl/seek_cd_pipe.sv
// Two-stage pipelined c/d field-sum unit: c = A+B+C, d = A + {A,B} + {A,B,C}.
// Define SEEK_CD_SAT_EN to clamp c/d at full scale instead of wrapping.
module seek_cd_pipe #(
    parameter int DW    = 32,
    parameter int FA    = 7,
    parameter int FB    = 13,
    parameter int FC    = 13,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*DW+1:0]   z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     c,
    output logic [DW+1:0]     d,
    output logic [CNT_W-1:0]  cnt
);
    localparam int ZW = 2*DW + 2;
    localparam int WW = 2*DW + 4;
`ifdef SEEK_CD_SAT_EN
    // Wide enough that no intermediate sum can overflow before the clamp.
    localparam int CW  = WW;
    localparam int DSW = WW;
`else
    localparam int CW  = DW;
    localparam int DSW = DW + 2;
`endif

    logic [FA-1:0]  fld_a;
    logic [FB-1:0]  fld_b;
    logic [FC-1:0]  fld_c;
    logic [WW-1:0]  a_x, b_x, ab_x, abc_x;
    logic           unused_z;

    assign fld_a    = z[ZW-1 -: FA];
    assign fld_b    = z[ZW-1-FA -: FB];
    assign fld_c    = z[ZW-1-FA-FB -: FC];
    assign unused_z = ^z;

    assign a_x   = WW'(fld_a);
    assign b_x   = WW'(fld_b);
    assign ab_x  = WW'({fld_a, fld_b});
    assign abc_x = WW'({fld_a, fld_b, fld_c});

    logic           s1_valid, s2_valid;
    logic           s1_adv, s2_adv;
    logic [CW-1:0]  s1_ab;
    logic [DSW-1:0] s1_aba, s1_abc;
    logic [CW-1:0]  c_sum;
    logic [DSW-1:0] d_sum;
    logic [DW-1:0]  c_nxt;
    logic [DW+1:0]  d_nxt;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // C is recovered from the low bits of the registered {A,B,C}.
    assign c_sum = s1_ab + CW'(s1_abc[FC-1:0]);
    assign d_sum = s1_aba + s1_abc;

`ifdef SEEK_CD_SAT_EN
    assign c_nxt = (c_sum > CW'({DW{1'b1}}))       ? {DW{1'b1}}     : c_sum[DW-1:0];
    assign d_nxt = (d_sum > DSW'({(DW+2){1'b1}}))  ? {(DW+2){1'b1}} : d_sum[DW+1:0];
`else
    assign c_nxt = c_sum;
    assign d_nxt = d_sum;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_ab    <= '0;
            s1_aba   <= '0;
            s1_abc   <= '0;
            c        <= '0;
            d        <= '0;
            cnt      <= '0;
        end else if (clr) begin
            // Flush drops any handshake this cycle; c/d keep their last values.
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            cnt      <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_ab  <= CW'(a_x + b_x);
                    s1_aba <= DSW'(ab_x + a_x);
                    s1_abc <= DSW'(abc_x);
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    c <= c_nxt;
                    d <= d_nxt;
                end
            end
            if (s2_valid && out_ready)
                cnt <= cnt + 1'b1;
        end
    end
endmodule
